// File: rtl/tlp_tx_framer_if.sv
// Interface bundling the request side and the DW stream side of tlp_tx_framer.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holding valid high keeps its
// payload stable until that transfer; ready may depend on state but never on
// the same-cycle valid of the other side.
//
// Modports: slave = the framer, master = request source plus link-layer sink.
interface tlp_tx_framer_if #(
  parameter int MAX_PAYLOAD_DW = 32
);
  logic                        req_valid_i;
  logic                        req_ready_o;
  logic [2:0]                  header_fmt_i;
  logic [4:0]                  header_type_i;
  logic [2:0]                  header_tc_i;
  logic [8:0]                  header_length_i;
  logic [15:0]                 header_requestID_i;
  logic [15:0]                 header_completID_i;
  logic [32*MAX_PAYLOAD_DW-1:0] data_i;
  logic [31:0]                 addr_i;
  logic                        tx_valid_o;
  logic                        tx_ready_i;
  logic [31:0]                 tx_data_o;
  logic                        tx_sop_o;
  logic                        tx_eop_o;
  logic [7:0]                  tag_o;
  logic                        err_o;

  modport slave (
    input  req_valid_i, header_fmt_i, header_type_i, header_tc_i,
           header_length_i, header_requestID_i, header_completID_i,
           data_i, addr_i, tx_ready_i,
    output req_ready_o, tx_valid_o, tx_data_o, tx_sop_o, tx_eop_o,
           tag_o, err_o
  );

  modport master (
    output req_valid_i, header_fmt_i, header_type_i, header_tc_i,
           header_length_i, header_requestID_i, header_completID_i,
           data_i, addr_i, tx_ready_i,
    input  req_ready_o, tx_valid_o, tx_data_o, tx_sop_o, tx_eop_o,
           tag_o, err_o
  );
endinterface

// File: rtl/tlp_tx_framer.sv
// tlp_tx_framer: turns one decoded request into a PCIe TLP streamed as 32-bit
// DW beats (header, payload, optional ECRC digest) with sop/eop framing.
// Optional feature macro: TLP_ECRC_EN (sets TD and appends a CRC-32 digest DW).
// state_o exposes the FSM encoding: 0 IDLE, 1 HDR, 2 DATA, 3 DGST.
module tlp_tx_framer #(
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int TAG_WIDTH      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  tlp_tx_framer_if.slave bus,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DGST = 2'd3
  } state_e;

  localparam int         IDXW    = $clog2(MAX_PAYLOAD_DW);
  localparam logic [8:0] MAX_LEN = 9'(MAX_PAYLOAD_DW);

`ifdef TLP_ECRC_EN
  localparam logic ECRC_ON = 1'b1;
`else
  localparam logic ECRC_ON = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [8:0]             idx_q, idx_d;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   tag_inc;
  logic                   err_q;
  logic [2:0]             fmt_q;
  logic [4:0]             type_q;
  logic [2:0]             tc_q;
  logic [8:0]             len_q;
  logic [15:0]            reqid_q;
  logic [15:0]            cplid_q;
  logic [31:0]            addr_q;
  logic [31:0]            data_q [MAX_PAYLOAD_DW];

  logic                   req_ready;
  logic                   accept;
  logic                   malformed;
  logic                   beat_hs;
  logic [8:0]             nh;
  logic [8:0]             nd;
  logic                   is_cpl;
  logic [3:0]             last_be;
  logic [11:0]            byte_cnt;
  logic [7:0]             tag8;
  logic [31:0]            hdr_dw;
  logic                   last_hdr;
  logic                   last_data;
  logic                   tx_valid;
  logic [31:0]            tx_data;
  logic                   tx_sop;
  logic                   tx_eop;

  assign req_ready = (state_q == IDLE);
  assign accept    = bus.req_valid_i && req_ready;
  assign malformed = bus.header_fmt_i[1] &&
                     ((bus.header_length_i == 9'd0) || (bus.header_length_i > MAX_LEN));
  assign beat_hs   = (state_q != IDLE) && bus.tx_ready_i;

  // Decode the registered request into beat counts and header sub-fields.
  always_comb begin
    nh        = fmt_q[0] ? 9'd4 : 9'd3;
    nd        = fmt_q[1] ? len_q : 9'd0;
    is_cpl    = (type_q == 5'b01010);
    last_be   = (nd <= 9'd1) ? 4'h0 : 4'hF;
    byte_cnt  = {1'b0, nd, 2'b00};
    last_hdr  = (idx_q == nh - 9'd1);
    last_data = (idx_q == nd - 9'd1);
    tag8      = '0;
    tag8[TAG_WIDTH-1:0] = tag_q;
  end

  // Select the header DW for the current header beat index.
  always_comb begin
    hdr_dw = '0;
    case (idx_q[1:0])
      2'd0: hdr_dw = {fmt_q, type_q, 1'b0, tc_q, 4'b0000, ECRC_ON, 1'b0,
                      2'b00, 2'b00, 1'b0, len_q};
      2'd1: begin
        if (is_cpl) hdr_dw = {cplid_q, 3'b000, 1'b0, byte_cnt};
        else        hdr_dw = {reqid_q, tag8, last_be, 4'hF};
      end
      2'd2: begin
        if (is_cpl)        hdr_dw = {reqid_q, tag8, 1'b0, addr_q[6:0]};
        else if (fmt_q[0]) hdr_dw = 32'h0;
        else               hdr_dw = {addr_q[31:2], 2'b00};
      end
      default: hdr_dw = {addr_q[31:2], 2'b00};
    endcase
  end

`ifdef TLP_ECRC_EN
  logic [31:0] crc_q;

  function automatic logic [31:0] crc32_dw(input logic [31:0] crc, input logic [31:0] dw);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ dw[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else               c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Running ECRC over every header/payload DW as it is handshaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          crc_q <= 32'hFFFF_FFFF;
    else if (accept)                     crc_q <= 32'hFFFF_FFFF;
    else if (beat_hs && state_q != DGST) crc_q <= crc32_dw(crc_q, tx_data);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, beat index and beat outputs; index only moves on a handshake.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tag_inc  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 32'h0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !malformed) begin
          state_d = HDR;
          idx_d   = 9'd0;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_dw;
        tx_sop   = (idx_q == 9'd0);
        tx_eop   = last_hdr && (nd == 9'd0) && !ECRC_ON;
        if (beat_hs) begin
          if (last_hdr) begin
            idx_d = 9'd0;
            if (nd != 9'd0) state_d = DATA;
            else if (ECRC_ON) state_d = DGST;
            else begin
              state_d = IDLE;
              tag_inc = 1'b1;
            end
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_q[idx_q[IDXW-1:0]];
        tx_eop   = last_data && !ECRC_ON;
        if (beat_hs) begin
          if (last_data) begin
            idx_d = 9'd0;
            if (ECRC_ON) state_d = DGST;
            else begin
              state_d = IDLE;
              tag_inc = 1'b1;
            end
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end
`ifdef TLP_ECRC_EN
      DGST: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q;
        tx_eop   = 1'b1;
        if (beat_hs) begin
          state_d = IDLE;
          tag_inc = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Request capture, beat index, tag counter and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      fmt_q   <= '0;
      type_q  <= '0;
      tc_q    <= '0;
      len_q   <= '0;
      reqid_q <= '0;
      cplid_q <= '0;
      addr_q  <= '0;
    end else begin
      idx_q <= idx_d;
      err_q <= accept && malformed;
      if (tag_inc) tag_q <= tag_q + 1'b1;
      if (accept) begin
        fmt_q   <= bus.header_fmt_i;
        type_q  <= bus.header_type_i;
        tc_q    <= bus.header_tc_i;
        len_q   <= bus.header_length_i;
        reqid_q <= bus.header_requestID_i;
        cplid_q <= bus.header_completID_i;
        addr_q  <= bus.addr_i;
      end
    end
  end

  // Payload buffer; needs no reset because it is only read after a capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < MAX_PAYLOAD_DW; k++) data_q[k] <= bus.data_i[32*k +: 32];
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.tx_valid_o  = tx_valid;
  assign bus.tx_data_o   = tx_data;
  assign bus.tx_sop_o    = tx_sop;
  assign bus.tx_eop_o    = tx_eop;
  assign bus.tag_o       = tag8;
  assign bus.err_o       = err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_tlp_tx_framer.sv
// Testbench for tlp_tx_framer: table of request vectors with literal expected
// header DWs, scoreboard of expected beats, plus reset/back-to-back/malformed
// and randomised-backpressure sequences. Honours TLP_ECRC_EN when defined.
module tb_tlp_tx_framer;
  localparam int MAXDW = 32;
`ifdef TLP_ECRC_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dut_state;
  always #5 clk = ~clk;

  tlp_tx_framer_if #(.MAX_PAYLOAD_DW(MAXDW)) bus();

  tlp_tx_framer #(.MAX_PAYLOAD_DW(MAXDW), .TAG_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (dut_state)
  );

  int checks = 0;
  int errors = 0;
  int model_tag = 0;
  int cyc = 0;
  int beats_seen = 0;
  int last_eop_cyc = -1;
  bit gap_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [33:0] held;
  int ready_mode = 0;
  logic [41:0] exp_q[$];

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [2:0]  tc;
    logic [8:0]  len;
    logic [15:0] rid;
    logic [15:0] cid;
    logic [31:0] addr;
    logic [31:0] seed;
    logic [31:0] step;
    logic [31:0] h0, h1, h2, h3;
    int          tag_dw;
    int          nh;
    int          nd;
    int          beats;
    int          rmode;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] dw);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ dw[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else               c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  always @(posedge clk) cyc++;

  // ---------------- sink backpressure ----------------
  initial begin
    bus.tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.tx_ready_i = 1'b1;
        1:       bus.tx_ready_i = ~bus.tx_ready_i;
        default: bus.tx_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [41:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.tx_valid_o)
        check("stall_hold", 64'({bus.tx_sop_o, bus.tx_eop_o, bus.tx_data_o}), 64'(held));
      prev_stall = bus.tx_valid_o && !bus.tx_ready_i;
      held = {bus.tx_sop_o, bus.tx_eop_o, bus.tx_data_o};
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none", bus.tx_data_o);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({bus.tag_o, bus.tx_sop_o, bus.tx_eop_o, bus.tx_data_o}), 64'(e));
        end
        if (gap_mode && bus.tx_sop_o && last_eop_cyc >= 0)
          check("idle_gap", 64'(cyc - last_eop_cyc), 64'(2));
        if (bus.tx_eop_o) last_eop_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [2:0] fmt, input logic [4:0] typ, input logic [2:0] tc,
                          input logic [8:0] len, input logic [15:0] rid, input logic [15:0] cid,
                          input logic [31:0] addr, input logic [31:0] seed, input logic [31:0] step);
    int n;
    @(negedge clk);
    bus.header_fmt_i       = fmt;
    bus.header_type_i      = typ;
    bus.header_tc_i        = tc;
    bus.header_length_i    = len;
    bus.header_requestID_i = rid;
    bus.header_completID_i = cid;
    bus.addr_i             = addr;
    for (int k = 0; k < MAXDW; k++) bus.data_i[32*k +: 32] = seed + 32'(k) * step;
    bus.req_valid_i = 1'b1;
    n = 0;
    while (!bus.req_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic push_pkt(input logic [31:0] h0, input logic [31:0] h1, input logic [31:0] h2,
                          input logic [31:0] h3, input int nh, input int nd,
                          input logic [31:0] seed, input logic [31:0] step);
    logic [31:0] dws[$];
    logic [31:0] crc;
    int n;
    dws.push_back(h0 | ((EXTRA != 0) ? 32'h0000_8000 : 32'h0));
    dws.push_back(h1);
    dws.push_back(h2);
    if (nh == 4) dws.push_back(h3);
    for (int k = 0; k < nd; k++) dws.push_back(seed + 32'(k) * step);
    crc = 32'hFFFF_FFFF;
    foreach (dws[i]) crc = crc_step(crc, dws[i]);
    if (EXTRA != 0) dws.push_back(~crc);
    n = dws.size();
    for (int i = 0; i < n; i++)
      exp_q.push_back({8'(model_tag), (i == 0), (i == n - 1), dws[i]});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.tx_valid_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    logic [31:0] h1, h2;
    h1 = v.h1;
    h2 = v.h2;
    if (v.tag_dw == 1) h1 = h1 | (32'(model_tag) << 8);
    else               h2 = h2 | (32'(model_tag) << 8);
    ready_mode = v.rmode;
    base = beats_seen;
    send_req(v.fmt, v.typ, v.tc, v.len, v.rid, v.cid, v.addr, v.seed, v.step);
    check("err_on_good", 64'(bus.err_o), 64'(0));
    push_pkt(v.h0, h1, h2, v.h3, v.nh, v.nd, v.seed, v.step);
    wait_drain();
    check("beat_count", 64'(beats_seen - base), 64'(v.beats + EXTRA));
    model_tag = (model_tag + 1) % 256;
    ready_mode = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.req_valid_i = 1'b0;
    bus.header_fmt_i = '0;
    bus.header_type_i = '0;
    bus.header_tc_i = '0;
    bus.header_length_i = '0;
    bus.header_requestID_i = '0;
    bus.header_completID_i = '0;
    bus.addr_i = '0;
    bus.data_i = '0;

    //        fmt    typ       tc    len    rid       cid       addr          seed          step
    //        h0            h1            h2            h3            tag_dw nh nd beats rmode
    vecs[0] = '{3'b010, 5'd0, 3'd0, 9'd4, 16'h0100, 16'h0000, 32'h0000_0020, 32'h0123_4567, 32'h0,
                32'h4000_0004, 32'h0100_00FF, 32'h0000_0020, 32'h0, 1, 3, 4, 7, 0};
    vecs[1] = '{3'b001, 5'd0, 3'd0, 9'd1, 16'h0100, 16'h0000, 32'h0000_0040, 32'h0, 32'h0,
                32'h2000_0001, 32'h0100_000F, 32'h0, 32'h0000_0040, 1, 4, 0, 4, 1};
    vecs[2] = '{3'b010, 5'b01010, 3'd0, 9'd2, 16'h0100, 16'hABCD, 32'h0000_1234, 32'hCAFE_0000, 32'h1,
                32'h4A00_0002, 32'hABCD_0008, 32'h0100_0034, 32'h0, 2, 3, 2, 5, 0};
    vecs[3] = '{3'b000, 5'd0, 3'd3, 9'd1, 16'h1234, 16'h0000, 32'h0000_1003, 32'h0, 32'h0,
                32'h0030_0001, 32'h1234_000F, 32'h0000_1000, 32'h0, 1, 3, 0, 3, 0};
    vecs[4] = '{3'b010, 5'd0, 3'd0, 9'd1, 16'h0001, 16'h0000, 32'h0000_0080, 32'hDEAD_BEEF, 32'h0,
                32'h4000_0001, 32'h0001_000F, 32'h0000_0080, 32'h0, 1, 3, 1, 4, 2};
    vecs[5] = '{3'b011, 5'd0, 3'd0, 9'd32, 16'h0200, 16'h0000, 32'hFFFF_FFFC, 32'h1000_0000, 32'h0101_0101,
                32'h6000_0020, 32'h0200_00FF, 32'h0, 32'hFFFF_FFFC, 1, 4, 32, 36, 2};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready_o), 64'(1));
    check("rst_tx_valid",  64'(bus.tx_valid_o), 64'(0));
    check("rst_sop_eop",   64'({bus.tx_sop_o, bus.tx_eop_o}), 64'(0));
    check("rst_tx_data",   64'(bus.tx_data_o), 64'(0));
    check("rst_err",       64'(bus.err_o), 64'(0));
    check("rst_tag",       64'(bus.tag_o), 64'(0));
    check("rst_state",     64'(dut_state), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Six back-to-back writes: tags 0..5, one idle tx cycle between packets.
    gap_mode = 1'b1;
    last_eop_cyc = -1;
    for (int i = 0; i < 6; i++) begin
      send_req(vecs[0].fmt, vecs[0].typ, vecs[0].tc, vecs[0].len, vecs[0].rid, vecs[0].cid,
               vecs[0].addr, vecs[0].seed, vecs[0].step);
      push_pkt(vecs[0].h0, vecs[0].h1 | (32'(model_tag) << 8), vecs[0].h2, vecs[0].h3,
               vecs[0].nh, vecs[0].nd, vecs[0].seed, vecs[0].step);
      model_tag++;
    end
    wait_drain();
    gap_mode = 1'b0;
    check("tag_after_b2b", 64'(bus.tag_o), 64'(6));

    // Table vectors.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Malformed requests: dropped, one-cycle err pulse, tag untouched.
    for (int i = 0; i < 2; i++) begin
      send_req(3'b010, 5'd0, 3'd0, (i == 0) ? 9'd0 : 9'd33, 16'h0100, 16'h0, 32'h100, 32'h0, 32'h0);
      check("mal_err_pulse", 64'(bus.err_o), 64'(1));
      check("mal_ready",     64'(bus.req_ready_o), 64'(1));
      check("mal_no_valid",  64'(bus.tx_valid_o), 64'(0));
      @(posedge clk);
      #1;
      check("mal_err_clear", 64'(bus.err_o), 64'(0));
      check("mal_tag",       64'(bus.tag_o), 64'(model_tag));
    end

    // Randomised memory requests under random backpressure.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      int r;
      r = int'($urandom_range(0, 3));
      v.fmt  = {1'b0, r[1:0]};
      v.typ  = 5'd0;
      v.tc   = 3'd0;
      v.len  = 9'($urandom_range(1, 32));
      v.rid  = 16'($urandom_range(0, 65535));
      v.cid  = 16'h0;
      v.addr = $urandom();
      v.seed = $urandom();
      v.step = $urandom();
      v.nd   = v.fmt[1] ? int'(v.len) : 0;
      v.nh   = v.fmt[0] ? 4 : 3;
      v.h0   = {v.fmt, 5'b0, 1'b0, 3'b0, 4'b0, 1'b0, 1'b0, 2'b0, 2'b0, 1'b0, v.len};
      v.h1   = {v.rid, 8'h00, (v.nd <= 1) ? 4'h0 : 4'hF, 4'hF};
      v.h2   = v.fmt[0] ? 32'h0 : {v.addr[31:2], 2'b00};
      v.h3   = {v.addr[31:2], 2'b00};
      v.tag_dw = 1;
      v.beats  = v.nh + v.nd;
      v.rmode  = 2;
      run_vec(v);
    end

    // Reset in the middle of a 7-beat write.
    begin
      int base;
      int n;
      base = beats_seen;
      send_req(vecs[0].fmt, vecs[0].typ, vecs[0].tc, vecs[0].len, vecs[0].rid, vecs[0].cid,
               vecs[0].addr, vecs[0].seed, vecs[0].step);
      push_pkt(vecs[0].h0, vecs[0].h1 | (32'(model_tag) << 8), vecs[0].h2, vecs[0].h3,
               vecs[0].nh, vecs[0].nd, vecs[0].seed, vecs[0].step);
      n = 0;
      while (beats_seen < base + 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("pre_reset_beats", 64'(beats_seen - base), 64'(2));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.tx_valid_o), 64'(0));
      check("mid_rst_eop",   64'(bus.tx_eop_o), 64'(0));
      check("mid_rst_ready", 64'(bus.req_ready_o), 64'(1));
      check("mid_rst_tag",   64'(bus.tag_o), 64'(0));
      exp_q.delete();
      model_tag = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
